// File: rtl/i2c_txn_sequencer_if.sv
// i2c_txn_sequencer_if: host-side and i2c_master-side signals of the transaction sequencer.
//   Host side   : start_i, dev_addr_i, reg_addr_i, rd_nwr_i, len_i, tx_push_i, tx_data_i, rx_pop_i,
//                 rx_data_o, tx_full_o, rx_empty_o, busy_o, done_tick_o, nack_err_o
//   Master side : cmd_o, din_o, wr_i2c_o (to i2c_master), ready_i, ack_i, dout_i (from i2c_master)
//   Suffixes are relative to the sequencer; modport slave is the sequencer, master is its environment.
interface i2c_txn_sequencer_if;
    logic       start_i;
    logic [6:0] dev_addr_i;
    logic [7:0] reg_addr_i;
    logic       rd_nwr_i;
    logic [3:0] len_i;
    logic       tx_push_i;
    logic [7:0] tx_data_i;
    logic       rx_pop_i;
    logic [7:0] rx_data_o;
    logic       tx_full_o;
    logic       rx_empty_o;
    logic       busy_o;
    logic       done_tick_o;
    logic       nack_err_o;
    logic [2:0] cmd_o;
    logic [7:0] din_o;
    logic       wr_i2c_o;
    logic       ready_i;
    logic       ack_i;
    logic [7:0] dout_i;

    modport slave (
        input  start_i, dev_addr_i, reg_addr_i, rd_nwr_i, len_i, tx_push_i, tx_data_i, rx_pop_i,
        input  ready_i, ack_i, dout_i,
        output rx_data_o, tx_full_o, rx_empty_o, busy_o, done_tick_o, nack_err_o,
        output cmd_o, din_o, wr_i2c_o
    );

    modport master (
        output start_i, dev_addr_i, reg_addr_i, rd_nwr_i, len_i, tx_push_i, tx_data_i, rx_pop_i,
        output ready_i, ack_i, dout_i,
        input  rx_data_o, tx_full_o, rx_empty_o, busy_o, done_tick_o, nack_err_o,
        input  cmd_o, din_o, wr_i2c_o
    );
endinterface

// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: I2C register-transaction engine driving an i2c_master command port.
//   Issues START / addr / reg / [RESTART / addr] / data / STOP, with write bytes taken from a
//   TX FIFO and read bytes stored into an RX FIFO.
//   Ports: clk, reset (async, active-high), bus (i2c_txn_sequencer_if.slave: host controls,
//          FIFO access, status, and the cmd/din/wr_i2c/ready/ack/dout link to i2c_master).
//   Parameters: DEPTH (FIFO depth, power of 2, max length), TIMEOUT_CYC (watchdog limit).
//   Optional: define I2C_SEQ_TIMEOUT_EN to enable the ready-wait watchdog.
module i2c_txn_sequencer #(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic               clk,
    input  logic               reset,
    i2c_txn_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [2:0] C_START = 3'd0, C_WR = 3'd1, C_RD = 3'd2, C_STOP = 3'd3, C_RESTART = 3'd4;

    typedef enum logic [3:0] {
        IDLE, S_START, S_ADDR, S_REG, S_WDATA, S_RESTART, S_ADDR_R, S_RDATA, S_STOP, S_DONE
    } state_t;
    // Per-command handshake: wait ready, strobe, blanked cycle, wait ready (complete).
    typedef enum logic [1:0] {P_ISSUE, P_STROBE, P_BLANK, P_CPLT} phase_t;

    state_t        state_q, cplt_state;
    phase_t        ph_q;
    logic [3:0]    cnt_q;
    logic [6:0]    dev_q;
    logic [7:0]    reg_q;
    logic          rd_q;
    logic          busy_q, done_q, nack_q, wr_q;
    logic [2:0]    cmd_q, issue_cmd;
    logic [7:0]    din_q, issue_din;
    logic          nack_hit, reject;

    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic          tx_push, tx_pop, rx_push, rx_pop;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    logic [WW-1:0] wd_q;
    logic          waiting;
    assign waiting = state_q != IDLE && state_q != S_DONE && !bus.ready_i
                     && (ph_q == P_ISSUE || ph_q == P_CPLT);
`endif

    always_comb begin
        tx_push  = bus.tx_push_i && tx_cnt_q != CW'(DEPTH);
        tx_pop   = state_q == S_WDATA && ph_q == P_ISSUE && bus.ready_i;
        rx_push  = state_q == S_RDATA && ph_q == P_CPLT && bus.ready_i && rx_cnt_q != CW'(DEPTH);
        rx_pop   = bus.rx_pop_i && rx_cnt_q != '0;
        tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        reject   = int'(bus.len_i) > DEPTH
                || (!bus.rd_nwr_i && int'(tx_cnt_q) < int'(bus.len_i))
                || (bus.rd_nwr_i && DEPTH - int'(rx_cnt_q) < int'(bus.len_i));
        issue_cmd = state_q == S_START   ? C_START
                  : state_q == S_RESTART ? C_RESTART
                  : state_q == S_RDATA   ? C_RD
                  : state_q == S_STOP    ? C_STOP
                  : C_WR;
        // For RD, din[0] asks i2c_master to NACK the last byte; cnt_q is not yet decremented here.
        issue_din = state_q == S_ADDR   ? {dev_q, 1'b0}
                  : state_q == S_REG    ? reg_q
                  : state_q == S_WDATA  ? tx_mem[tx_rp_q]
                  : state_q == S_ADDR_R ? {dev_q, 1'b1}
                  : state_q == S_RDATA  ? {7'd0, cnt_q == 4'd1}
                  : 8'd0;
        nack_hit = bus.ack_i && (state_q == S_ADDR || state_q == S_REG
                              || state_q == S_WDATA || state_q == S_ADDR_R);
        // Data states count down at issue, so cnt_q==0 at completion means the last byte is done.
        cplt_state = nack_hit               ? S_STOP
                   : state_q == S_START     ? S_ADDR
                   : state_q == S_ADDR      ? (cnt_q == 4'd0 ? S_STOP : S_REG)
                   : state_q == S_REG       ? (rd_q ? S_RESTART : S_WDATA)
                   : state_q == S_RESTART   ? S_ADDR_R
                   : state_q == S_ADDR_R    ? S_RDATA
                   : (state_q == S_WDATA || state_q == S_RDATA) ? (cnt_q == 4'd0 ? S_STOP : state_q)
                   : S_DONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ph_q    <= P_ISSUE;
            cnt_q   <= '0;
            dev_q   <= '0;
            reg_q   <= '0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            nack_q  <= 1'b0;
            wr_q    <= 1'b0;
            cmd_q   <= '0;
            din_q   <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
            wd_q    <= '0;
`endif
        end else begin
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        if (reject) begin
                            nack_q <= 1'b1;
                            done_q <= 1'b1;
                        end else begin
                            nack_q  <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= S_START;
                            ph_q    <= P_ISSUE;
                            cnt_q   <= bus.len_i;
                            dev_q   <= bus.dev_addr_i;
                            reg_q   <= bus.reg_addr_i;
                            rd_q    <= bus.rd_nwr_i;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    case (ph_q)
                        P_ISSUE: begin
                            if (bus.ready_i) begin
                                wr_q  <= 1'b1;
                                cmd_q <= issue_cmd;
                                din_q <= issue_din;
                                ph_q  <= P_STROBE;
                                if (state_q == S_WDATA || state_q == S_RDATA) cnt_q <= cnt_q - 4'd1;
                            end
                        end
                        P_STROBE: ph_q <= P_BLANK;
                        P_BLANK:  ph_q <= P_CPLT;
                        default: begin
                            if (bus.ready_i) begin
                                ph_q    <= P_ISSUE;
                                state_q <= cplt_state;
                                if (nack_hit) nack_q <= 1'b1;
                                if (cplt_state == S_DONE) done_q <= 1'b1;
                            end
                        end
                    endcase
                end
            endcase
`ifdef I2C_SEQ_TIMEOUT_EN
            wd_q <= waiting ? wd_q + WW'(1) : '0;
            // Watchdog abandons the transaction without a STOP; the last assignment wins.
            if (waiting && wd_q == WW'(TIMEOUT_CYC - 1)) begin
                state_q <= IDLE;
                ph_q    <= P_ISSUE;
                busy_q  <= 1'b0;
                nack_q  <= 1'b1;
                done_q  <= 1'b1;
                wd_q    <= '0;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            tx_wp_q  <= tx_wp_q + AW'(tx_push);
            tx_rp_q  <= tx_rp_q + AW'(tx_pop);
            tx_cnt_q <= tx_cnt_d;
            rx_wp_q  <= rx_wp_q + AW'(rx_push);
            rx_rp_q  <= rx_rp_q + AW'(rx_pop);
            rx_cnt_q <= rx_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= bus.tx_data_i;
        if (rx_push) rx_mem[rx_wp_q] <= bus.dout_i;
    end

    assign bus.rx_data_o   = rx_mem[rx_rp_q];
    assign bus.tx_full_o   = tx_cnt_q == CW'(DEPTH);
    assign bus.rx_empty_o  = rx_cnt_q == '0;
    assign bus.busy_o      = busy_q;
    assign bus.done_tick_o = done_q;
    assign bus.nack_err_o  = nack_q;
    assign bus.cmd_o       = cmd_q;
    assign bus.din_o       = din_q;
    assign bus.wr_i2c_o    = wr_q;
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb_i2c_txn_sequencer: directed bench with an i2c_master model and a command scoreboard.
module tb_i2c_txn_sequencer;
    logic clk = 1'b0;
    logic reset;
    int total = 0;
    int bad = 0;
    logic [10:0] exp_q[$];
    logic [7:0] rd_q[$];
    logic nack_en = 1'b0;
    logic [7:0] nack_byte = 8'h90;
    logic hang = 1'b0;

    i2c_txn_sequencer_if bus();
    i2c_txn_sequencer #(.DEPTH(8), .TIMEOUT_CYC(200)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    function automatic logic [10:0] key(input logic [2:0] c, input logic [7:0] d);
        return c == 3'd1 ? {c, d} : c == 3'd2 ? {c, 7'd0, d[0]} : {c, 8'd0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic ex(input logic [2:0] c, input logic [7:0] d);
        exp_q.push_back(key(c, d));
    endtask

    task automatic push_tx(input logic [7:0] b);
        @(negedge clk);
        bus.tx_push_i = 1'b1;
        bus.tx_data_i = b;
        @(negedge clk);
        bus.tx_push_i = 1'b0;
    endtask

    task automatic start_txn(input logic [6:0] d, input logic [7:0] r, input logic rd, input logic [3:0] n);
        @(negedge clk);
        bus.dev_addr_i = d;
        bus.reg_addr_i = r;
        bus.rd_nwr_i   = rd;
        bus.len_i      = n;
        bus.start_i    = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, output logic nk);
        logic seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            seen = bus.done_tick_o;
        end
        chk({tag, "_done"}, seen, 1'b1);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
        nk = bus.nack_err_o;
    endtask

    // i2c_master model: checks each strobed command, then is busy for a few cycles.
    initial begin
        logic [10:0] e;
        logic a;
        logic [7:0] r;
        forever begin
            @(negedge clk);
            if (bus.wr_i2c_o === 1'b1) begin
                e = exp_q.size() > 0 ? exp_q.pop_front() : 11'h7FF;
                chk("cmd", key(bus.cmd_o, bus.din_o), e);
                a = bus.cmd_o == 3'd1 && nack_en && bus.din_o == nack_byte;
                r = (bus.cmd_o == 3'd2 && rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
                bus.ready_i = 1'b0;
                repeat (3) @(negedge clk);
                if (!hang) begin
                    bus.ack_i   = a;
                    bus.dout_i  = r;
                    bus.ready_i = 1'b1;
                end
            end
        end
    end

    initial begin
        logic nk;
        logic found;
        int dcnt;
        logic [7:0] rx_exp [3];
        rx_exp[0] = 8'h11; rx_exp[1] = 8'h22; rx_exp[2] = 8'h33;
        reset = 1'b1;
        bus.start_i = 1'b0; bus.dev_addr_i = '0; bus.reg_addr_i = '0; bus.rd_nwr_i = 1'b0;
        bus.len_i = '0; bus.tx_push_i = 1'b0; bus.tx_data_i = '0; bus.rx_pop_i = 1'b0;
        bus.ready_i = 1'b1; bus.ack_i = 1'b0; bus.dout_i = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", bus.busy_o, 1'b0);
        chk("rst_done", bus.done_tick_o, 1'b0);
        chk("rst_nack", bus.nack_err_o, 1'b0);
        chk("rst_wr", bus.wr_i2c_o, 1'b0);
        chk("rst_cmd", bus.cmd_o, 3'd0);
        chk("rst_din", bus.din_o, 8'd0);
        chk("rst_txfull", bus.tx_full_o, 1'b0);
        chk("rst_rxempty", bus.rx_empty_o, 1'b1);

        // Write len=2, plus an ignored start while busy.
        push_tx(8'hA5);
        push_tx(8'h3C);
        ex(0, 0); ex(1, 8'h90); ex(1, 8'h10); ex(1, 8'hA5); ex(1, 8'h3C); ex(3, 0);
        start_txn(7'h48, 8'h10, 1'b0, 4'd2);
        chk("wr_busy", bus.busy_o, 1'b1);
        repeat (5) @(negedge clk);
        bus.dev_addr_i = 7'h11; bus.rd_nwr_i = 1'b1; bus.len_i = 4'd1; bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_done("wr", nk);
        chk("wr_nack", nk, 1'b0);
        @(negedge clk);
        chk("wr_idle_busy", bus.busy_o, 1'b0);

        // Read len=3.
        rd_q = '{8'h11, 8'h22, 8'h33};
        ex(0, 0); ex(1, 8'h90); ex(1, 8'h00); ex(4, 0); ex(1, 8'h91);
        ex(2, 0); ex(2, 0); ex(2, 1); ex(3, 0);
        start_txn(7'h48, 8'h00, 1'b1, 4'd3);
        wait_done("rd", nk);
        chk("rd_nack", nk, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("rd_rxempty0", bus.rx_empty_o, 1'b0);
            chk("rd_rxdata", bus.rx_data_o, rx_exp[i]);
            bus.rx_pop_i = 1'b1;
            @(negedge clk);
            bus.rx_pop_i = 1'b0;
        end
        chk("rd_rxempty1", bus.rx_empty_o, 1'b1);

        // NACK on address byte; the queued TX byte must survive.
        push_tx(8'h77);
        nack_en = 1'b1;
        ex(0, 0); ex(1, 8'h90); ex(3, 0);
        start_txn(7'h48, 8'h10, 1'b0, 4'd1);
        wait_done("nack", nk);
        chk("nack_err", nk, 1'b1);
        nack_en = 1'b0;
        for (int i = 1; i <= 6; i++) push_tx(8'(i));
        chk("tx_notfull", bus.tx_full_o, 1'b0);
        push_tx(8'h07);
        chk("tx_full", bus.tx_full_o, 1'b1);
        push_tx(8'hEE);
        chk("tx_full_hold", bus.tx_full_o, 1'b1);

        // Full-depth write across the pointer wrap.
        ex(0, 0); ex(1, 8'hA0); ex(1, 8'h20); ex(1, 8'h77);
        for (int i = 1; i <= 7; i++) ex(1, 8'(i));
        ex(3, 0);
        start_txn(7'h50, 8'h20, 1'b0, 4'd8);
        wait_done("wr8", nk);
        chk("wr8_nack_clr", nk, 1'b0);
        chk("wr8_txempty", bus.tx_full_o, 1'b0);

        // Rejects: too few TX bytes, then len > DEPTH.
        push_tx(8'hB1);
        push_tx(8'hB2);
        start_txn(7'h48, 8'h10, 1'b0, 4'd4);
        chk("rej_done", bus.done_tick_o, 1'b1);
        chk("rej_nack", bus.nack_err_o, 1'b1);
        chk("rej_busy", bus.busy_o, 1'b0);
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            dcnt += int'(bus.done_tick_o);
        end
        chk("rej_one_tick", dcnt, 0);
        start_txn(7'h48, 8'h10, 1'b1, 4'd9);
        chk("rej9_done", bus.done_tick_o, 1'b1);
        chk("rej9_busy", bus.busy_o, 1'b0);

        // Address probe.
        ex(0, 0); ex(1, 8'h78); ex(3, 0);
        start_txn(7'h3C, 8'h00, 1'b0, 4'd0);
        wait_done("probe", nk);
        chk("probe_nack", nk, 1'b0);

        // Reset while the last RD is outstanding.
        rd_q = '{8'h44, 8'h55};
        ex(0, 0); ex(1, 8'h90); ex(1, 8'h05); ex(4, 0); ex(1, 8'h91); ex(2, 0); ex(2, 1);
        start_txn(7'h48, 8'h05, 1'b1, 4'd2);
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            found = bus.wr_i2c_o && bus.cmd_o == 3'd2 && bus.din_o[0];
        end
        chk("rst_rd_seen", found, 1'b1);
        #1;
        chk("pre_rst_rxempty", bus.rx_empty_o, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", bus.busy_o, 1'b0);
        chk("mid_rst_rxempty", bus.rx_empty_o, 1'b1);
        chk("mid_rst_wr", bus.wr_i2c_o, 1'b0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        exp_q.delete();
        rd_q.delete();

`ifdef I2C_SEQ_TIMEOUT_EN
        hang = 1'b1;
        ex(0, 0);
        start_txn(7'h3C, 8'h00, 1'b0, 4'd0);
        wait_done("wdog", nk);
        chk("wdog_nack", nk, 1'b1);
        hang = 1'b0;
        bus.ready_i = 1'b1;
        @(negedge clk);
        chk("wdog_busy", bus.busy_o, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
